// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a single ALU whose result is
// registered inside the ALU. One operation is in flight at a time and moves
// through IDLE -> EXEC -> CAPT -> RESP.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqK_valid / reqK_ready   request handshake of requester K (ready is
//                             combinational from valid while IDLE)
//   reqK_rs1/rs2/inst         operands and instruction of requester K
//   alu_rs1/alu_rs2/alu_inst  operands to the ALU (zero outside EXEC/CAPT)
//   alu_res / alu_zf          registered ALU result and zero flag
//   rspK_valid / rspK_ready   response handshake of requester K
//   rsp_res / rsp_zf          captured result, held until the next capture
//   ops_done                  wrapping count of completed responses
//
// Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win
// simultaneous requests; left undefined, simultaneous requests alternate
// (round-robin on the last granted requester).
module alu_arbiter #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [N-1:0] req0_rs1,
  input  logic [N-1:0] req0_rs2,
  input  logic [N-1:0] req1_rs1,
  input  logic [N-1:0] req1_rs2,
  input  logic [31:0]  req0_inst,
  input  logic [31:0]  req1_inst,
  output logic [N-1:0] alu_rs1,
  output logic [N-1:0] alu_rs2,
  output logic [31:0]  alu_inst,
  input  logic [N-1:0] alu_res,
  input  logic         alu_zf,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  input  logic         rsp0_ready,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp_res,
  output logic         rsp_zf,
  output logic [15:0]  ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t state;
  logic   grant_id;   // requester owning the in-flight operation
  logic   pick;       // requester that would win a handshake this cycle
  logic   rsp_done;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic   last_grant;
`endif

  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    pick = ~req0_valid;
`else
    pick = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;
`endif
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE && !rst) begin
      req0_ready = req0_valid && !pick;
      req1_ready = req1_valid &&  pick;
    end
  end

  // Response valids are only ever set for the owner, so a ready from the
  // other requester (or a ready with no valid) cannot complete anything.
  assign rsp_done = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  // The ALU operand registers double as the request latch: loaded on the
  // handshake, cleared when leaving CAPT, so they read zero in IDLE/RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
      alu_rs1    <= '0;
      alu_rs2    <= '0;
      alu_inst   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_res    <= '0;
      rsp_zf     <= 1'b0;
      ops_done   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            grant_id   <= pick;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= pick;
`endif
            alu_rs1    <= pick ? req1_rs1  : req0_rs1;
            alu_rs2    <= pick ? req1_rs2  : req0_rs2;
            alu_inst   <= pick ? req1_inst : req0_inst;
            state      <= EXEC;
          end
        end
        EXEC: state <= CAPT;
        CAPT: begin
          rsp_res    <= alu_res;
          rsp_zf     <= alu_zf;
          alu_rs1    <= '0;
          alu_rs2    <= '0;
          alu_inst   <= '0;
          rsp0_valid <= ~grant_id;
          rsp1_valid <= grant_id;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            ops_done   <= ops_done + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. Contains a one-cycle
// registered ALU stand-in, a directed vector table, hand-written multi-cycle
// sequences and a randomized run against a transaction-timing model.
// Honours ALU_ARB_FIXED_PRIO_EN the same way the design does.
module tb_alu_arbiter;
  localparam int unsigned N = 32;
  localparam logic [31:0] ADD = 32'h00000033;
  localparam logic [31:0] SUB = 32'h40000033;

  logic         clk;
  logic         rst;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [N-1:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
  logic [31:0]  req0_inst, req1_inst;
  logic [N-1:0] alu_rs1, alu_rs2, alu_res;
  logic [31:0]  alu_inst;
  logic         alu_zf;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [N-1:0] rsp_res;
  logic         rsp_zf;
  logic [15:0]  ops_done;

  int tests = 0;
  int fails = 0;

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
    .req0_inst(req0_inst), .req1_inst(req1_inst),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_inst(alu_inst),
    .alu_res(alu_res), .alu_zf(alu_zf),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_res(rsp_res), .rsp_zf(rsp_zf), .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [31:0] inst);
    return (inst == SUB) ? a - b : a + b;
  endfunction

  // ALU stand-in: result registered one cycle after the operands.
  always @(posedge clk) begin
    alu_res <= alu_f(alu_rs1, alu_rs2, alu_inst);
    alu_zf  <= (alu_f(alu_rs1, alu_rs2, alu_inst) == '0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int winner(input logic v0, input logic v1, input logic last);
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (v0) return 0;
    if (v1) return 1;
    return -1;
`else
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
`endif
  endfunction

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_rs1 = '0; req0_rs2 = '0; req1_rs1 = '0; req1_rs2 = '0;
    req0_inst = '0; req1_inst = '0;
  endtask

  // Leaves the bench 1 time unit after a posedge with rst low.
  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
  endtask

  typedef struct {
    logic         v0, v1;
    logic [N-1:0] a0, b0, a1, b1;
    logic [31:0]  i0, i1;
    logic         g;
    logic [N-1:0] res;
    logic         zf;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic v1,
                              input logic [N-1:0] a0, input logic [N-1:0] b0, input logic [31:0] i0,
                              input logic [N-1:0] a1, input logic [N-1:0] b1, input logic [31:0] i1,
                              input logic g, input logic [N-1:0] res, input logic zf);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.a0 = a0; v.b0 = b0; v.i0 = i0;
    v.a1 = a1; v.b1 = b1; v.i1 = i1; v.g = g; v.res = res; v.zf = zf;
    return v;
  endfunction

  int exp_ops;

  // One operation from IDLE: grant, EXEC operands, T+3 latency, result, count.
  task automatic run_vec(input vec_t v, input int idx);
    req0_valid = v.v0; req0_rs1 = v.a0; req0_rs2 = v.b0; req0_inst = v.i0;
    req1_valid = v.v1; req1_rs1 = v.a1; req1_rs2 = v.b1; req1_inst = v.i1;
    @(negedge clk);
    check($sformatf("vec%0d_ready", idx), {req1_ready, req0_ready}, v.g ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    check($sformatf("vec%0d_exec_inst", idx), alu_inst, v.g ? v.i1 : v.i0);
    check($sformatf("vec%0d_exec_rs1", idx), alu_rs1, v.g ? v.a1 : v.a0);
    check($sformatf("vec%0d_t1_rspv", idx), {rsp1_valid, rsp0_valid}, 2'b00);
    @(posedge clk); @(negedge clk);
    check($sformatf("vec%0d_capt_rs2", idx), alu_rs2, v.g ? v.b1 : v.b0);
    check($sformatf("vec%0d_t2_rspv", idx), {rsp1_valid, rsp0_valid}, 2'b00);
    @(posedge clk); @(negedge clk);
    check($sformatf("vec%0d_t3_rspv", idx), {rsp1_valid, rsp0_valid}, v.g ? 2'b10 : 2'b01);
    check($sformatf("vec%0d_res", idx), rsp_res, v.res);
    check($sformatf("vec%0d_zf", idx), rsp_zf, v.zf);
    check($sformatf("vec%0d_resp_inst", idx), alu_inst, 32'h0);
    if (v.g) rsp1_ready = 1; else rsp0_ready = 1;
    @(posedge clk); #1;
    rsp0_ready = 0; rsp1_ready = 0;
    exp_ops++;
    @(negedge clk);
    check($sformatf("vec%0d_ops", idx), ops_done, exp_ops);
    check($sformatf("vec%0d_done_rspv", idx), {rsp1_valid, rsp0_valid}, 2'b00);
    check($sformatf("vec%0d_hold_res", idx), rsp_res, v.res);
    @(posedge clk); #1;
  endtask

  // Randomized run against a timing model: an accepted op occupies the ALU
  // in the two cycles after acceptance and answers from the third onwards.
  task automatic random_phase(input int cycles);
    bit           busy = 0;
    int           tacc = 0;
    int           w;
    logic         owner = 0, last = 1, hzf = 0, in_alu;
    logic [N-1:0] la = '0, lb = '0, hres = '0;
    logic [31:0]  li = '0;
    logic [15:0]  ops = '0;
    logic [1:0]   erdy, evld;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      rst        = ($urandom_range(0, 127) == 0);
      req0_valid = $urandom_range(0, 1) != 0;
      req1_valid = $urandom_range(0, 1) != 0;
      req0_rs1   = $urandom;
      req0_rs2   = ($urandom_range(0, 3) == 0) ? req0_rs1 : $urandom;
      req0_inst  = ($urandom_range(0, 1) != 0) ? SUB : ADD;
      req1_rs1   = $urandom;
      req1_rs2   = ($urandom_range(0, 3) == 0) ? req1_rs1 : $urandom;
      req1_inst  = ($urandom_range(0, 1) != 0) ? SUB : ADD;
      rsp0_ready = $urandom_range(0, 2) != 0;
      rsp1_ready = $urandom_range(0, 2) != 0;
      w      = winner(req0_valid, req1_valid, last);
      erdy   = (!busy && !rst && w >= 0) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
      evld   = (busy && (c - tacc) >= 3) ? (owner ? 2'b10 : 2'b01) : 2'b00;
      in_alu = busy && ((c - tacc) == 1 || (c - tacc) == 2);
      @(negedge clk);
      check("rnd_ready", {req1_ready, req0_ready}, erdy);
      check("rnd_rspv", {rsp1_valid, rsp0_valid}, evld);
      check("rnd_alu", {alu_inst, alu_rs1}, in_alu ? {li, la} : 64'h0);
      check("rnd_rsp", {rsp_zf, rsp_res}, {hzf, hres});
      check("rnd_ops", ops_done, ops);
      @(posedge clk);
      if (rst) begin
        busy = 0; last = 1; hres = '0; hzf = 0; ops = '0;
      end else if (!busy) begin
        if (w >= 0) begin
          busy = 1; tacc = c; owner = (w == 1); last = owner;
          la = owner ? req1_rs1 : req0_rs1;
          lb = owner ? req1_rs2 : req0_rs2;
          li = owner ? req1_inst : req0_inst;
        end
      end else begin
        if ((c - tacc) == 2) begin
          hres = alu_f(la, lb, li);
          hzf  = (hres == '0);
        end
        if (evld != 2'b00 && (owner ? rsp1_ready : rsp0_ready)) begin
          busy = 0; ops = ops + 16'd1;
        end
      end
      #1;
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   gq[$];
    int   cq[$];

    // Reset: ready held low even with both requests pending.
    idle_inputs();
    rst = 1; req0_valid = 1; req1_valid = 1;
    @(posedge clk); @(negedge clk);
    check("rst_ready", {req1_ready, req0_ready}, 2'b00);
    @(posedge clk); #1;
    rst = 0; req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    check("rst_ops", ops_done, 16'h0);
    check("rst_rsp", {rsp_zf, rsp_res}, 33'h0);
    check("rst_rspv", {rsp1_valid, rsp0_valid}, 2'b00);
    check("rst_alu", {alu_inst, alu_rs1}, 64'h0);
    check("rst_alu_rs2", alu_rs2, 32'h0);
    @(posedge clk); #1;

    // Directed vectors, starting right after reset (requester 0 favoured).
    vecs[0] = mk(1, 0, 5, 7, ADD, 0, 0, ADD, 0, 12, 0);
    vecs[1] = mk(0, 1, 0, 0, ADD, 9, 9, SUB, 1, 0, 1);
    vecs[2] = mk(1, 1, 100, 50, SUB, 1, 2, ADD, 0, 50, 0);
`ifdef ALU_ARB_FIXED_PRIO_EN
    vecs[3] = mk(1, 1, 10, 10, SUB, 32'hFFFFFFFF, 2, ADD, 0, 0, 1);
`else
    vecs[3] = mk(1, 1, 10, 10, SUB, 32'hFFFFFFFF, 2, ADD, 1, 1, 0);
`endif
    vecs[4] = mk(1, 1, 3, 5, SUB, 7, 8, ADD, 0, 32'hFFFFFFFE, 0);
    vecs[5] = mk(0, 1, 0, 0, ADD, 32'h80000000, 32'h80000000, ADD, 1, 0, 1);
    exp_ops = 0;
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Contention: both requesting continuously, responses consumed at once.
    do_reset();
    req0_valid = 1; req0_rs1 = 1; req0_rs2 = 2; req0_inst = ADD;
    req1_valid = 1; req1_rs1 = 3; req1_rs2 = 4; req1_inst = ADD;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req0_ready) begin gq.push_back(0); cq.push_back(c); end
      if (req1_ready) begin gq.push_back(1); cq.push_back(c); end
      @(posedge clk); #1;
    end
    idle_inputs();
    check("cont_grant_count", gq.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        check($sformatf("cont_grant%0d", i), gq[i], 0);
`else
        check($sformatf("cont_grant%0d", i), gq[i], i % 2);
`endif
        if (i > 0) check($sformatf("cont_gap%0d", i), cq[i] - cq[i-1], 4);
      end
    end

    // Backpressure on requester 0 with requester 1 waiting.
    do_reset();
    req0_valid = 1; req0_rs1 = 20; req0_rs2 = 22; req0_inst = ADD;
    @(negedge clk);
    check("bp_accept", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 1; req1_rs1 = 1; req1_rs2 = 1; req1_inst = ADD;
    rsp1_ready = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_busy_ready1", req1_ready, 1'b0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", {rsp1_valid, rsp0_valid}, 2'b01);
      check("bp_hold_res", rsp_res, 42);
      check("bp_hold_ready1", req1_ready, 1'b0);
      @(posedge clk); #1;
    end
    check("bp_hold_ops", ops_done, 16'h0);
    rsp0_ready = 1;
    @(posedge clk); #1;
    rsp0_ready = 0; rsp1_ready = 0;
    @(negedge clk);
    check("bp_after_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    check("bp_after_idle", req1_ready, 1'b1);
    check("bp_after_ops", ops_done, 16'h1);
    req1_valid = 0;
    @(posedge clk); #1;

    // Reset during EXEC drops the operation.
    do_reset();
    req0_valid = 1; req0_rs1 = 1; req0_rs2 = 2; req0_inst = ADD;
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    check("rmid_exec_inst", alu_inst, ADD);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("rmid_inst", alu_inst, 32'h0);
    check("rmid_ops", ops_done, 16'h0);
    for (int k = 0; k < 4; k++) begin
      check("rmid_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
      @(posedge clk); @(negedge clk);
    end
    @(posedge clk); #1;

    random_phase(2000);

    // Counter wrap: preset to all ones while idle, then complete one op.
    do_reset();
    @(negedge clk);
    force dut.ops_done = 16'hFFFF;
    #1;
    release dut.ops_done;
    @(posedge clk); #1;
    req1_valid = 1; req1_rs1 = 4; req1_rs2 = 4; req1_inst = ADD;
    @(posedge clk); #1;
    req1_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check("wrap_rspv", {rsp1_valid, rsp0_valid}, 2'b10);
    rsp1_ready = 1;
    @(posedge clk); #1;
    rsp1_ready = 0;
    @(negedge clk);
    check("wrap_ops", ops_done, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: N, 32, datapath width of rs1/rs2/result (matches ALU).
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester k has an ALU operation pending.
- req0_ready / req1_ready  out  1  requester k operation accepted this cycle.
- req0_rs1, req0_rs2 / req1_rs1, req1_rs2  in  N  operands of requester k.
- req0_inst / req1_inst  in  32  instruction word of requester k.
- alu_rs1, alu_rs2  out  N  operands driven to the ALU.
- alu_inst  out  32  instruction driven to the ALU.
- alu_res  in  N  ALU result, registered inside the ALU.
- alu_zf  in  1  ALU zero flag.
- rsp0_valid / rsp1_valid  out  1  result available for requester k.
- rsp0_ready / rsp1_ready  in  1  requester k consumes its result.
- rsp_res  out  N  captured result.
- rsp_zf  out  1  captured zero flag.
- ops_done  out  16  count of completed operations.
REQ-003 SHALL use one clock and a synchronous, active-high reset; clk and rst SHALL be the only clock/reset ports.

Function
REQ-004 SHALL implement FSM states IDLE, EXEC, CAPT, RESP.
REQ-005 IDLE: reqK_ready=1 only for the granted requester, only when its valid=1 (combinational from valid); handshake latches rs1/rs2/inst/grant id; next state EXEC.
REQ-006 EXEC (1 cycle): alu_rs1/alu_rs2/alu_inst driven from latched values; next state CAPT.
REQ-007 CAPT (1 cycle): operands held stable; alu_res/alu_zf registered into rsp_res/rsp_zf; next state RESP.
REQ-008 RESP: rspK_valid=1 for the granted id only; rsp_res/rsp_zf stable; stays until rspK_ready=1, then IDLE next cycle.
REQ-009 Latency: handshake in cycle T gives rspK_valid in cycle T+3 at the earliest; sustained throughput is one operation per 4 cycles.
REQ-010 Outside EXEC/CAPT: alu_rs1=0, alu_rs2=0, alu_inst=0.
REQ-011 Both ready outputs SHALL be 0 in EXEC, CAPT and RESP; only one operation is in flight.
REQ-012 Round-robin: last_grant register; if both valid in IDLE, grant !last_grant; if one valid, grant it; last_grant updates on every handshake.
REQ-013 rspK_ready while rspK_valid=0 SHALL be ignored; rsp1_ready during a requester-0 response SHALL be ignored.
REQ-014 ops_done SHALL increment by 1 on each RESP completion (valid&ready) and wrap 16'hFFFF->0.
REQ-015 rsp_res/rsp_zf SHALL hold the last captured value after RESP until the next CAPT.

Reset
REQ-016 rst=1 at a posedge SHALL force IDLE from any state and drop any in-flight operation with no response.
REQ-017 Reset values: last_grant=1 (requester 0 wins first); ops_done=0; rsp_res=0; rsp_zf=0; all valid/ready outputs 0; alu_* outputs 0.
REQ-018 While rst=1, reqK_ready SHALL be 0 regardless of reqK_valid.

Configuration
REQ-019 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins simultaneous requests and last_grant is unused. Undefined: round-robin per REQ-012.

Verification
REQ-020 Single op: req0 rs1=5, rs2=7, inst=32'h00000033 accepted at T -> rsp0_valid at T+3, rsp_res=12, rsp_zf=0, ops_done=1.
REQ-021 Zero flag: req1 rs1=9, rs2=9, inst=32'h40000033 -> rsp1_valid, rsp_res=0, rsp_zf=1.
REQ-022 Contention: after reset both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; each ready pulse 4 cycles apart. With ALU_ARB_FIXED_PRIO_EN -> grants 0,0,0,0.
REQ-023 Backpressure: rsp0_ready=0 for 5 cycles in RESP -> rsp0_valid and rsp_res stable; req1_ready=0 throughout; IDLE one cycle after rsp0_ready=1.
REQ-024 Reset mid-op: rst=1 during EXEC -> IDLE next cycle, no rspK_valid, ops_done=0, alu_inst=0.
REQ-025 Wrap: preload 65535 completions (or force ops_done=16'hFFFF) then one more -> ops_done=0.
